// File: rtl/serial_tx_framer_if.sv
// Word-transfer handshake between a word source and serial_tx_framer.
interface serial_tx_framer_if #(
  parameter int unsigned N = 8
) ();
  logic         tx_valid;
  logic [N-1:0] tx_data;
  logic         tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/serial_tx_framer.sv
// Parallel-to-serial framer: start bit, N data bits LSB-first, optional even
// parity, stop bit; each bit held CLKS_PER_BIT clocks on a registered line.
module serial_tx_framer #(
  parameter int unsigned N            = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1
) (
  input  logic                clk,
  input  logic                rst,
  serial_tx_framer_if.slave   tx_if,
  output logic                serial_out,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = $clog2(N);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_LAST = BW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [N-1:0]  r_shreg, w_shreg_nxt;
  logic          r_parity, w_parity_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [BW-1:0] r_bit, w_bit_nxt;
  logic          w_tc, w_serial_nxt, w_done_nxt;
  logic          r_serial, r_busy, r_ready, r_done;

  assign w_tc           = (r_cnt == C_LAST);
  assign tx_if.tx_ready = r_ready;
  assign serial_out     = r_serial;
  assign busy           = r_busy;
  assign frame_done     = r_done;

  // Next-state, datapath and next line value; the line is registered from
  // the next state so each bit appears in the first cycle of its state.
  always_comb begin
    w_state_nxt  = r_state;
    w_shreg_nxt  = r_shreg;
    w_parity_nxt = r_parity;
    w_cnt_nxt    = r_cnt;
    w_bit_nxt    = r_bit;
    w_done_nxt   = 1'b0;
    w_serial_nxt = 1'b1;

    if (r_state != S_IDLE) begin
      w_cnt_nxt = w_tc ? '0 : r_cnt + CW'(1);
    end

    case (r_state)
      S_IDLE: begin
        if (tx_if.tx_valid) begin
          w_state_nxt  = S_START;
          w_shreg_nxt  = tx_if.tx_data;
          w_parity_nxt = ^tx_if.tx_data;
          w_cnt_nxt    = '0;
          w_bit_nxt    = '0;
        end
      end
      S_START: begin
        if (w_tc) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        if (w_tc) begin
          w_shreg_nxt = r_shreg >> 1;
          if (r_bit == B_LAST) begin
            w_state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_nxt = r_bit + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_tc) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_tc) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    case (w_state_nxt)
      S_START:  w_serial_nxt = 1'b0;
      S_DATA:   w_serial_nxt = w_shreg_nxt[0];
      S_PARITY: w_serial_nxt = w_parity_nxt;
      default:  w_serial_nxt = 1'b1;
    endcase
  end

  // State and output registers; reset wins over a same-cycle handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_shreg  <= '0;
      r_parity <= 1'b0;
      r_cnt    <= '0;
      r_bit    <= '0;
      r_serial <= 1'b1;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shreg  <= w_shreg_nxt;
      r_parity <= w_parity_nxt;
      r_cnt    <= w_cnt_nxt;
      r_bit    <= w_bit_nxt;
      r_serial <= w_serial_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
      r_ready  <= (w_state_nxt == S_IDLE);
      r_done   <= w_done_nxt;
    end
  end

endmodule

// File: doc/serial_tx_framer.md
Name: serial_tx_framer

Overview:
Parallel-to-serial transmitter that drives the serial link consumed by our LSB-first shift-register receiver. It accepts an N-bit word over a valid/ready handshake. It emits a framed bitstream on one line: start bit, N data bits LSB-first, optional even-parity bit, stop bit. Each bit is held for a programmable number of clocks.

Parameters:
N, 8, data word width (>= 2)
CLKS_PER_BIT, 4, clocks each serial bit is held (>= 1)
PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
tx_valid  input  1  word on tx_data is offered
tx_data  input  N  word to transmit
tx_ready  output  1  block can accept a word (high only in IDLE)
serial_out  output  1  serial line, idle high, registered
busy  output  1  frame in progress (state != IDLE)
frame_done  output  1  one-clock pulse after stop bit completes

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: sampled on clk rising edge. The block enters IDLE with serial_out=1, busy=0, frame_done=0, tx_ready=1. Reset overrides everything, including a handshake in the same cycle.
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake: tx_ready = (state==IDLE). Transfer occurs on an edge where tx_valid && tx_ready. On that edge:
  - tx_data is captured into an internal N-bit shift register.
  - The parity bit is computed as the XOR of all N data bits.
  - The bit-period counter and the data-bit counter are cleared.
  - The state goes to START.
- tx_valid while busy is ignored. tx_data changes after capture have no effect.
- serial_out is registered and follows the state:
  - IDLE = 1
  - START = 0
  - DATA = current shift-register bit 0
  - PARITY = parity bit
  - STOP = 1
- Bit timing: each non-IDLE state bit is held exactly CLKS_PER_BIT clocks, counted by a counter running 0..CLKS_PER_BIT-1.
  - At the terminal count, the next bit begins.
  - In DATA, the shift register shifts right by one (LSB out first) at each terminal count.
  - After N data bits, the next state is PARITY if PARITY_EN=1, otherwise STOP.
  - STOP terminal count leads to IDLE.
- Frame length: F = 2 + N + PARITY_EN bits, i.e. F*CLKS_PER_BIT clocks.
- Cycle-level timing: let the handshake occur at edge k.
  - serial_out=0 for cycles k+1 .. k+CLKS_PER_BIT.
  - Data bit i occupies cycles k+1+CLKS_PER_BIT*(1+i) onward, for CLKS_PER_BIT cycles.
  - The first IDLE cycle is k+1+F*CLKS_PER_BIT.
- frame_done: high for exactly one clock, during the first IDLE cycle after STOP. It is not asserted after a reset-aborted frame.
- Back-to-back: if tx_valid is high in the first IDLE cycle, the next word is accepted at that edge. This gives exactly one idle-high clock between the stop bit and the next start bit.
- CLKS_PER_BIT=1: one clock per bit, with no extra idle beyond the one IDLE cycle.
- Reset mid-frame: the frame is aborted. On the next cycle serial_out=1 and the state is IDLE. Shift-register contents are don't-care.
- Widths: the bit counter is sized for N, and the period counter for CLKS_PER_BIT. No wrap-around is permitted beyond terminal count.

Test Plan:
1. Reset: hold rst=1 for 2 clocks with tx_valid=1 -> no frame starts; serial_out=1, tx_ready=1, busy=0, frame_done=0.
2. N=8, CLKS_PER_BIT=4, PARITY_EN=1, send 0xA5 with handshake at edge k -> line shows bits 0,1,0,1,0,0,1,0,1,0(parity),1(stop), each held 4 clocks. tx_ready=0 and busy=1 for cycles k+1..k+44. frame_done=1 only in cycle k+45.
3. Parity check: 0x07 -> parity bit 1; 0x00 -> data bits all 0, parity 0; 0xFF -> parity 0.
4. Back-to-back: tx_valid held high with 0x3C, then 0xC3 presented at the first IDLE cycle. Toggle tx_data mid-frame -> first frame is unaffected. The second start bit begins exactly 1 clock after the first stop bit ends, and the second frame carries 0xC3.
5. Reset mid-frame: assert rst for 1 clock during data bit 3 of 0x96 -> next cycle serial_out=1, IDLE, no frame_done. A following 0x5A is then transmitted correctly.
6. PARITY_EN=0, CLKS_PER_BIT=1, send 0x81 -> 10 consecutive cycles 0,1,0,0,0,0,0,0,1,1, then frame_done pulse with tx_ready=1.
